// File: rtl/rob_multi_cdb.sv
// rob_multi_cdb: circular reorder buffer fed by NUM_CDB result buses.
//   Insert : insert_valid/insert_ready/insert_reg/insert_wb -> insert_tag ({1,tail})
//   Lookup : src{1,2}_tag -> src{1,2}_ready/src{1,2}_data (comb, CDB bypass)
//   CDB    : cdb_valid[k], cdb_tag/cdb_data packed per channel k
//   Retire : registered commit_valid/we/reg/data/tag, one entry per cycle
//   Status : count, empty; flush clears everything synchronously
module rob_multi_cdb #(
  parameter int DEPTH   = 16,
  parameter int IDX_W   = $clog2(DEPTH),
  parameter int TAG_W   = IDX_W + 1,
  parameter int DATA_W  = 32,
  parameter int REG_W   = 5,
  parameter int NUM_CDB = 3,
  parameter int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      insert_valid,
  output logic                      insert_ready,
  input  logic [REG_W-1:0]          insert_reg,
  input  logic                      insert_wb,
  output logic [TAG_W-1:0]          insert_tag,
  input  logic [TAG_W-1:0]          src1_tag,
  input  logic [TAG_W-1:0]          src2_tag,
  output logic                      src1_ready,
  output logic                      src2_ready,
  output logic [DATA_W-1:0]         src1_data,
  output logic [DATA_W-1:0]         src2_data,
  input  logic [NUM_CDB-1:0]        cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0]  cdb_tag,
  input  logic [NUM_CDB*DATA_W-1:0] cdb_data,
  input  logic                      flush,
  output logic                      commit_valid,
  output logic                      commit_we,
  output logic [REG_W-1:0]          commit_reg,
  output logic [DATA_W-1:0]         commit_data,
  output logic [TAG_W-1:0]          commit_tag,
  output logic [CNT_W-1:0]          count,
  output logic                      empty
);

  logic [DEPTH-1:0]             ent_busy, ent_rdy, ent_wb;
  logic [DEPTH-1:0][REG_W-1:0]  ent_reg;
  logic [DEPTH-1:0][DATA_W-1:0] ent_data;
  logic [IDX_W-1:0]             head, tail;
  logic                         ins, ret;

  assign insert_ready = (count != CNT_W'(DEPTH));
  assign insert_tag   = {1'b1, tail};
  assign empty        = (count == '0);
  assign ins          = insert_valid & insert_ready & ~flush;
  assign ret          = (count != '0) & ent_rdy[head] & ~flush;

  // Per-entry CDB capture; scanning channels high->low lets the lowest k win.
  logic [DEPTH-1:0]             cdb_wr;
  logic [DEPTH-1:0][DATA_W-1:0] cdb_wdata;
  always_comb begin
    cdb_wr    = '0;
    cdb_wdata = '0;
    for (int i = 0; i < DEPTH; i++)
      for (int k = NUM_CDB-1; k >= 0; k--)
        if (cdb_valid[k] && cdb_tag[k*TAG_W+TAG_W-1] &&
            cdb_tag[k*TAG_W +: IDX_W] == IDX_W'(i) && ent_busy[i]) begin
          cdb_wr[i]    = 1'b1;
          cdb_wdata[i] = cdb_data[k*DATA_W +: DATA_W];
        end
  end

  // Control state: pointers, busy/ready flags, commit port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      ent_busy     <= '0;
      ent_rdy      <= '0;
      commit_valid <= 1'b0;
      commit_we    <= 1'b0;
      commit_reg   <= '0;
      commit_data  <= '0;
      commit_tag   <= '0;
    end else if (flush) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      ent_busy     <= '0;
      ent_rdy      <= '0;
      commit_valid <= 1'b0;
      commit_we    <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (cdb_wr[i]) ent_rdy[i] <= 1'b1;
      if (ins) begin
        ent_busy[tail] <= 1'b1;
        ent_rdy[tail]  <= 1'b0;
        tail           <= tail + 1'b1;
      end
      // Placed after the CDB loop so a retiring head ends up clear.
      if (ret) begin
        ent_busy[head] <= 1'b0;
        ent_rdy[head]  <= 1'b0;
        head           <= head + 1'b1;
        commit_reg     <= ent_reg[head];
        commit_data    <= ent_data[head];
        commit_tag     <= {1'b1, head};
      end
      commit_valid <= ret;
      commit_we    <= ret & ent_wb[head];
      count        <= count + CNT_W'(ins) - CNT_W'(ret);
    end
  end

  // Payload fields carry no reset; busy/ready qualify them.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++)
      if (cdb_wr[i]) ent_data[i] <= cdb_wdata[i];
    if (ins) begin
      ent_reg[tail] <= insert_reg;
      ent_wb[tail]  <= insert_wb;
    end
  end

  logic [1:0][TAG_W-1:0]  src_tag;
  logic [1:0]             src_ready;
  logic [1:0][DATA_W-1:0] src_data;
  assign src_tag    = {src2_tag, src1_tag};
  assign src1_ready = src_ready[0];
  assign src2_ready = src_ready[1];
  assign src1_data  = src_data[0];
  assign src2_data  = src_data[1];

  for (genvar s = 0; s < 2; s++) begin : g_src
    rob_src_lookup #(
      .DEPTH(DEPTH), .IDX_W(IDX_W), .TAG_W(TAG_W),
      .DATA_W(DATA_W), .NUM_CDB(NUM_CDB)
    ) u_lookup (
      .tag       (src_tag[s]),
      .cdb_valid (cdb_valid),
      .cdb_tag   (cdb_tag),
      .cdb_data  (cdb_data),
      .ent_rdy   (ent_rdy),
      .ent_data  (ent_data),
      .ready     (src_ready[s]),
      .data      (src_data[s])
    );
  end

endmodule

// rob_src_lookup: one operand port. Priority: free tag, lowest CDB hit,
// stored ready entry, else not ready (data 0).
module rob_src_lookup #(
  parameter int DEPTH   = 16,
  parameter int IDX_W   = 4,
  parameter int TAG_W   = 5,
  parameter int DATA_W  = 32,
  parameter int NUM_CDB = 3
) (
  input  logic [TAG_W-1:0]          tag,
  input  logic [NUM_CDB-1:0]        cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0]  cdb_tag,
  input  logic [NUM_CDB*DATA_W-1:0] cdb_data,
  input  logic [DEPTH-1:0]          ent_rdy,
  input  logic [DEPTH-1:0][DATA_W-1:0] ent_data,
  output logic                      ready,
  output logic [DATA_W-1:0]         data
);
  logic              hit;
  logic [DATA_W-1:0] hit_data;

  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    for (int k = NUM_CDB-1; k >= 0; k--)
      if (cdb_valid[k] && cdb_tag[k*TAG_W +: TAG_W] == tag) begin
        hit      = 1'b1;
        hit_data = cdb_data[k*DATA_W +: DATA_W];
      end
  end

  always_comb begin
    ready = 1'b0;
    data  = '0;
    if (tag == '0) begin
      ready = 1'b1;
    end else if (hit) begin
      ready = 1'b1;
      data  = hit_data;
    end else if (ent_rdy[tag[IDX_W-1:0]]) begin
      ready = 1'b1;
      data  = ent_data[tag[IDX_W-1:0]];
    end
  end
endmodule

// File: tb/tb_rob_multi_cdb.sv
module tb_rob_multi_cdb;
  localparam int DEPTH = 16, IDX_W = 4, TAG_W = 5, DATA_W = 32;
  localparam int REG_W = 5, NUM_CDB = 3, CNT_W = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic insert_valid = 1'b0, insert_wb = 1'b0, flush = 1'b0;
  logic [REG_W-1:0] insert_reg = '0;
  logic [TAG_W-1:0] src1_tag = '0, src2_tag = '0;
  logic [NUM_CDB-1:0] cdb_valid = '0;
  logic [NUM_CDB*TAG_W-1:0] cdb_tag = '0;
  logic [NUM_CDB*DATA_W-1:0] cdb_data = '0;
  logic insert_ready, src1_ready, src2_ready, commit_valid, commit_we, empty;
  logic [TAG_W-1:0] insert_tag, commit_tag;
  logic [DATA_W-1:0] src1_data, src2_data, commit_data;
  logic [REG_W-1:0] commit_reg;
  logic [CNT_W-1:0] count;

  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  rob_multi_cdb #(.DEPTH(DEPTH), .DATA_W(DATA_W), .REG_W(REG_W), .NUM_CDB(NUM_CDB)) dut (
    .clk(clk), .rst(rst),
    .insert_valid(insert_valid), .insert_ready(insert_ready),
    .insert_reg(insert_reg), .insert_wb(insert_wb), .insert_tag(insert_tag),
    .src1_tag(src1_tag), .src2_tag(src2_tag),
    .src1_ready(src1_ready), .src2_ready(src2_ready),
    .src1_data(src1_data), .src2_data(src2_data),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .flush(flush),
    .commit_valid(commit_valid), .commit_we(commit_we), .commit_reg(commit_reg),
    .commit_data(commit_data), .commit_tag(commit_tag),
    .count(count), .empty(empty)
  );

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cdb(input int k, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
    cdb_valid[k] = 1'b1;
    cdb_tag[k*TAG_W +: TAG_W] = t;
    cdb_data[k*DATA_W +: DATA_W] = d;
  endtask

  task automatic clr_cdb();
    cdb_valid = '0;
    cdb_tag   = '0;
    cdb_data  = '0;
  endtask

  initial begin
    // reset state
    tick();
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_cvalid", commit_valid, 0);
    chk("rst_ready", insert_ready, 1);
    chk("rst_itag", insert_tag, 5'h10);
    rst = 1'b1;

    // three inserts, regs 1..3
    for (int r = 1; r <= 3; r++) begin
      insert_valid = 1'b1; insert_reg = REG_W'(r); insert_wb = 1'b1;
      chk("ins_tag", insert_tag, 64'h10 + 64'(r) - 1);
      tick();
    end
    insert_valid = 1'b0;
    chk("ins3_count", count, 3);
    chk("ins3_cvalid", commit_valid, 0);

    // out-of-order completion, in-order retire
    set_cdb(2, 5'h12, 32'h33); tick(); clr_cdb();
    chk("ooo_a_cvalid", commit_valid, 0);
    set_cdb(0, 5'h10, 32'h11); tick(); clr_cdb();
    chk("ooo_b_cvalid", commit_valid, 0);
    set_cdb(1, 5'h11, 32'h22); tick(); clr_cdb();
    chk("c1_valid", commit_valid, 1);
    chk("c1_we", commit_we, 1);
    chk("c1_reg", commit_reg, 1);
    chk("c1_data", commit_data, 32'h11);
    chk("c1_tag", commit_tag, 5'h10);
    chk("c1_count", count, 2);
    tick();
    chk("c2_valid", commit_valid, 1);
    chk("c2_reg", commit_reg, 2);
    chk("c2_data", commit_data, 32'h22);
    tick();
    chk("c3_valid", commit_valid, 1);
    chk("c3_reg", commit_reg, 3);
    chk("c3_data", commit_data, 32'h33);
    chk("c3_tag", commit_tag, 5'h12);
    chk("c3_count", count, 0);
    chk("c3_empty", empty, 1);
    tick();
    chk("idle_cvalid", commit_valid, 0);
    chk("idle_reg_hold", commit_reg, 3);

    // operand lookup: CDB bypass, lowest channel wins, free tag
    src1_tag = 5'h14; src2_tag = 5'h00;
    set_cdb(1, 5'h14, 32'hAB);
    set_cdb(2, 5'h14, 32'hCD);
    #1;
    chk("byp_rdy", src1_ready, 1);
    chk("byp_data", src1_data, 32'hAB);
    chk("free_rdy", src2_ready, 1);
    chk("free_data", src2_data, 0);
    clr_cdb();
    src1_tag = 5'h12;
    #1;
    chk("retired_rdy", src1_ready, 0);
    chk("retired_data", src1_data, 0);

    // fill, refuse 17th, retire-while-full, wrap
    flush = 1'b1; tick(); flush = 1'b0;
    chk("fl0_count", count, 0);
    chk("fl0_itag", insert_tag, 5'h10);
    for (int i = 0; i < DEPTH; i++) begin
      insert_valid = 1'b1; insert_reg = REG_W'(i); insert_wb = 1'b1;
      tick();
    end
    chk("full_count", count, 16);
    chk("full_ready", insert_ready, 0);
    chk("full_itag", insert_tag, 5'h10);
    insert_reg = 5'd7; insert_wb = 1'b0;
    set_cdb(0, 5'h10, 32'h55); tick(); clr_cdb();
    chk("refuse_count", count, 16);
    chk("refuse_cvalid", commit_valid, 0);
    src1_tag = 5'h10;
    #1;
    chk("stored_rdy", src1_ready, 1);
    chk("stored_data", src1_data, 32'h55);
    tick();
    chk("rf_cvalid", commit_valid, 1);
    chk("rf_cdata", commit_data, 32'h55);
    chk("rf_creg", commit_reg, 0);
    chk("rf_count", count, 15);
    chk("rf_ready", insert_ready, 1);
    chk("rf_itag", insert_tag, 5'h10);
    tick();
    insert_valid = 1'b0;
    chk("wrap_count", count, 16);
    chk("wrap_itag", insert_tag, 5'h11);
    chk("wrap_src_rdy", src1_ready, 0);

    // flush with five entries and a ready head
    flush = 1'b1; tick(); flush = 1'b0;
    for (int i = 0; i < 5; i++) begin
      insert_valid = 1'b1; insert_reg = REG_W'(i + 1); insert_wb = 1'b1;
      tick();
    end
    insert_valid = 1'b0;
    set_cdb(0, 5'h10, 32'h99); tick(); clr_cdb();
    chk("pre_fl_count", count, 5);
    flush = 1'b1; insert_valid = 1'b1;
    set_cdb(1, 5'h11, 32'h12);
    tick();
    flush = 1'b0; insert_valid = 1'b0; clr_cdb();
    chk("fl_cvalid", commit_valid, 0);
    chk("fl_count", count, 0);
    chk("fl_empty", empty, 1);
    chk("fl_itag", insert_tag, 5'h10);
    src1_tag = 5'h11;
    #1;
    chk("fl_src_rdy", src1_ready, 0);

    // no-writeback entry, retire with simultaneous insert
    insert_valid = 1'b1; insert_reg = 5'd9; insert_wb = 1'b0;
    tick();
    insert_valid = 1'b0;
    set_cdb(0, 5'h10, 32'h77); tick(); clr_cdb();
    insert_valid = 1'b1; insert_reg = 5'd4; insert_wb = 1'b1;
    tick();
    insert_valid = 1'b0;
    chk("nwb_cvalid", commit_valid, 1);
    chk("nwb_we", commit_we, 0);
    chk("nwb_reg", commit_reg, 9);
    chk("nwb_data", commit_data, 32'h77);
    chk("nwb_count", count, 1);
    chk("nwb_itag", insert_tag, 5'h12);

    // asynchronous reset mid-cycle
    #1;
    rst = 1'b0;
    #1;
    chk("arst_count", count, 0);
    chk("arst_empty", empty, 1);
    chk("arst_cvalid", commit_valid, 0);
    chk("arst_creg", commit_reg, 0);
    chk("arst_cdata", commit_data, 0);
    chk("arst_ctag", commit_tag, 0);
    chk("arst_itag", insert_tag, 5'h10);
    rst = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
